// File: rtl/alu_op_sequencer_pkg.sv
// Shared select codes and sequencer state encoding for the 4-bit ALU interface.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational 4-bit ALU: accepts a command, drives the ALU, captures
// its outputs into a held response, and maintains an accumulator plus a sticky carry.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ALU_LAT = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_src,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_wb,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc,
  output logic             sticky_c,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'((ALU_LAT == 0) ? 0 : ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [LatW-1:0]  wait_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             wb_q;
  logic             accept, capture, issuing;

  assign accept  = cmd_valid & cmd_ready;
  assign issuing = (state_q == StIssue) || (state_q == StWait);
  assign capture = (ALU_LAT == 0) ? (state_q == StIssue)
                                  : ((state_q == StWait) && (wait_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = (ALU_LAT == 0) ? StResp : StWait;
      StWait:  if (wait_q == '0) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // Held low during reset even though the state register already reads StIdle.
    cmd_ready = rst_n && (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    alu_a     = issuing ? a_q : '0;
    alu_b     = issuing ? b_q : '0;
    alu_s     = issuing ? op_q : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (state_q == StIssue) begin
      wait_q <= LatLast;
    end else if ((state_q == StWait) && (wait_q != '0)) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  // Operand a is resolved from the accumulator as it stands at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OpAdd;
      a_q  <= '0;
      b_q  <= '0;
      wb_q <= 1'b0;
    end else if (accept) begin
      op_q <= alu_op_e'(cmd_op);
      a_q  <= cmd_src ? cmd_a : acc;
      b_q  <= cmd_b;
      wb_q <= cmd_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y     <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      op_count  <= '0;
    end else if (capture) begin
      rsp_y     <= alu_y;
      rsp_carry <= alu_carry;
      rsp_zero  <= alu_zero;
      op_count  <= op_count + 1'b1;
    end
  end

  // acc_clr takes priority over a coincident writeback or carry capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sticky_c <= 1'b0;
    end else if (acc_clr) begin
      acc      <= '0;
      sticky_c <= 1'b0;
    end else if (capture) begin
      if (wb_q) acc <= alu_y;
      sticky_c <= sticky_c | alu_carry;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (ALU_LAT=0 and ALU_LAT=2), each paired with a 4-bit ALU model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, cmd_valid, cmd_ready, cmd_src, cmd_wb, acc_clr;
  logic [1:0][2:0] cmd_op, alu_s;
  logic [1:0][3:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y, acc;
  logic [1:0]      alu_carry, alu_zero, rsp_valid, rsp_ready, rsp_carry, rsp_zero, sticky_c;
  logic [1:0][7:0] op_count;

  int checks = 0;
  int failures = 0;

  // Reference ALU: {carry, zero, y}; SUB carry is the borrow, SHL carry is the bit shifted out.
  function automatic logic [5:0] alu_f(logic [2:0] s, logic [3:0] a, logic [3:0] b);
    logic [4:0] r;
    case (s)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, ~a};
      3'd6:    r = {1'b0, a} << b;
      default: r = {1'b0, a >> b};
    endcase
    return {r[4], r[3:0] == 4'd0, r[3:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {alu_carry[g], alu_zero[g], alu_y[g]} = alu_f(alu_s[g], alu_a[g], alu_b[g]);

    alu_op_sequencer #(.WIDTH(4), .ALU_LAT(g * 2), .CNT_W(8)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_op   (cmd_op[g]),
      .cmd_src  (cmd_src[g]),
      .cmd_a    (cmd_a[g]),
      .cmd_b    (cmd_b[g]),
      .cmd_wb   (cmd_wb[g]),
      .acc_clr  (acc_clr[g]),
      .alu_a    (alu_a[g]),
      .alu_b    (alu_b[g]),
      .alu_s    (alu_s[g]),
      .alu_y    (alu_y[g]),
      .alu_carry(alu_carry[g]),
      .alu_zero (alu_zero[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_y    (rsp_y[g]),
      .rsp_carry(rsp_carry[g]),
      .rsp_zero (rsp_zero[g]),
      .acc      (acc[g]),
      .sticky_c (sticky_c[g]),
      .op_count (op_count[g])
    );
  end

  task automatic chk(input int d, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL d%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
    end
  endtask

  // Waits for cmd_ready, presents one command, returns at the negedge after the accept edge.
  task automatic issue(input int d, input logic [2:0] op, input logic src, input logic [3:0] a,
                       input logic [3:0] b, input logic wb, input logic [3:0] exp_a);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(d, "cmd_ready_timeout", 32'(n < 20), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_src[d]   = src;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    cmd_wb[d]    = wb;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    chk(d, "alu_a", 32'(alu_a[d]), 32'(exp_a));
    chk(d, "alu_b", 32'(alu_b[d]), 32'(b));
    chk(d, "alu_s", 32'(alu_s[d]), 32'(op));
  endtask

  // Counts edges to rsp_valid; optionally pulses acc_clr across the capture edge.
  task automatic await_rsp(input int d, input logic clr, input logic [3:0] ey, input logic ec,
                           input logic ez);
    int lat = 0;
    while (!rsp_valid[d] && lat < 20) begin
      if (lat == d * 2) acc_clr[d] = clr;
      @(negedge clk);
      acc_clr[d] = 1'b0;
      lat++;
    end
    chk(d, "latency", 32'(lat), 32'(1 + d * 2));
    chk(d, "rsp_y", 32'(rsp_y[d]), 32'(ey));
    chk(d, "rsp_carry", 32'(rsp_carry[d]), 32'(ec));
    chk(d, "rsp_zero", 32'(rsp_zero[d]), 32'(ez));
    chk(d, "cmd_ready_in_resp", 32'(cmd_ready[d]), 32'd0);
  endtask

  task automatic release_rsp(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk(d, "rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
    chk(d, "cmd_ready_back", 32'(cmd_ready[d]), 32'd1);
    chk(d, "alu_s_idle", 32'(alu_s[d]), 32'd0);
  endtask

  task automatic run_dut(input int d);
    // Reset state.
    chk(d, "rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk(d, "rst_acc", 32'(acc[d]), 32'd0);
    chk(d, "rst_op_count", 32'(op_count[d]), 32'd0);
    chk(d, "rst_alu_a", 32'(alu_a[d]), 32'd0);
    chk(d, "rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);

    // ADD 9+8 overflows to 1 with carry.
    issue(d, 3'd0, 1'b1, 4'd9, 4'd8, 1'b0, 4'd9);
    await_rsp(d, 1'b0, 4'h1, 1'b1, 1'b0);
    chk(d, "sticky_after_add", 32'(sticky_c[d]), 32'd1);
    release_rsp(d);
    chk(d, "op_count_1", 32'(op_count[d]), 32'd1);

    issue(d, 3'd1, 1'b1, 4'd3, 4'd3, 1'b0, 4'd3);
    await_rsp(d, 1'b0, 4'h0, 1'b0, 1'b1);
    release_rsp(d);
    issue(d, 3'd1, 1'b1, 4'd2, 4'd3, 1'b0, 4'd2);
    await_rsp(d, 1'b0, 4'hF, 1'b1, 1'b0);
    release_rsp(d);

    // Standalone acc_clr in IDLE.
    acc_clr[d] = 1'b1;
    @(negedge clk);
    acc_clr[d] = 1'b0;
    chk(d, "clr_sticky", 32'(sticky_c[d]), 32'd0);
    chk(d, "clr_op_count", 32'(op_count[d]), 32'd3);

    // Accumulator chain.
    issue(d, 3'd0, 1'b1, 4'd5, 4'd0, 1'b1, 4'd5);
    await_rsp(d, 1'b0, 4'h5, 1'b0, 1'b0);
    chk(d, "chain_acc5", 32'(acc[d]), 32'h5);
    release_rsp(d);
    issue(d, 3'd6, 1'b0, 4'hF, 4'd1, 1'b1, 4'h5);
    await_rsp(d, 1'b0, 4'hA, 1'b0, 1'b0);
    chk(d, "chain_accA", 32'(acc[d]), 32'hA);
    release_rsp(d);
    issue(d, 3'd5, 1'b0, 4'h0, 4'd0, 1'b0, 4'hA);
    await_rsp(d, 1'b0, 4'h5, 1'b0, 1'b0);
    chk(d, "chain_acc_kept", 32'(acc[d]), 32'hA);
    chk(d, "chain_sticky", 32'(sticky_c[d]), 32'd0);
    release_rsp(d);

    // Backpressure with a competing command offered.
    issue(d, 3'd0, 1'b1, 4'd1, 4'd1, 1'b0, 4'd1);
    await_rsp(d, 1'b0, 4'h2, 1'b0, 1'b0);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = 3'd3;
    cmd_src[d]   = 1'b1;
    cmd_a[d]     = 4'd3;
    cmd_b[d]     = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(d, "bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk(d, "bp_rsp_y", 32'(rsp_y[d]), 32'h2);
      chk(d, "bp_cmd_ready", 32'(cmd_ready[d]), 32'd0);
    end
    cmd_valid[d] = 1'b0;
    chk(d, "bp_op_count", 32'(op_count[d]), 32'd7);
    release_rsp(d);
    @(negedge clk);
    chk(d, "bp_no_accept", 32'(op_count[d]), 32'd7);

    // acc_clr on the capture edge of a writeback with carry.
    issue(d, 3'd0, 1'b1, 4'd9, 4'd8, 1'b1, 4'd9);
    await_rsp(d, 1'b1, 4'h1, 1'b1, 1'b0);
    chk(d, "capclr_acc", 32'(acc[d]), 32'd0);
    chk(d, "capclr_sticky", 32'(sticky_c[d]), 32'd0);
    chk(d, "capclr_op_count", 32'(op_count[d]), 32'd8);
    release_rsp(d);

    // Reset while the command is in flight.
    issue(d, 3'd0, 1'b1, 4'd9, 4'd8, 1'b1, 4'd9);
    rst_n[d] = 1'b0;
    #1;
    chk(d, "mid_rst_cmd_ready", 32'(cmd_ready[d]), 32'd0);
    chk(d, "mid_rst_rsp_y", 32'(rsp_y[d]), 32'd0);
    chk(d, "mid_rst_op_count", 32'(op_count[d]), 32'd0);
    chk(d, "mid_rst_alu_a", 32'(alu_a[d]), 32'd0);
    chk(d, "mid_rst_acc", 32'(acc[d]), 32'd0);
    @(negedge clk);
    rst_n[d] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(d, "post_rst_no_rsp", 32'(rsp_valid[d]), 32'd0);
    end
    issue(d, 3'd0, 1'b1, 4'd2, 4'd3, 1'b0, 4'd2);
    await_rsp(d, 1'b0, 4'h5, 1'b0, 1'b0);
    release_rsp(d);
    chk(d, "post_rst_op_count", 32'(op_count[d]), 32'd1);
  endtask

  initial begin
    rst_n     = '0;
    cmd_valid = '0;
    cmd_src   = '0;
    cmd_wb    = '0;
    acc_clr   = '0;
    rsp_ready = '0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    #12;
    chk(0, "in_rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    chk(1, "in_rst_cmd_ready", 32'(cmd_ready[1]), 32'd0);
    @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    run_dut(0);
    run_dut(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
